// File: rtl/alu_control_md_if.sv
// Decode/multiply-divide request and response bundle between the register-read
// stage (master) and the ALU control block (slave).
interface alu_control_md_if #(parameter int WIDTH = 32);
  logic             valid;
  logic [2:0]       uc;
  logic [5:0]       funct;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       alu_sel;
  logic             illegal;
  logic             busy;
  logic             stall;
  logic             md_done;
  logic [WIDTH-1:0] md_result;
  logic             md_result_valid;

  modport master (
    output valid, uc, funct, op_a, op_b,
    input  alu_sel, illegal, busy, stall, md_done, md_result, md_result_valid
  );

  modport slave (
    input  valid, uc, funct, op_a, op_b,
    output alu_sel, illegal, busy, stall, md_done, md_result, md_result_valid
  );
endinterface

// File: rtl/alu_control_md.sv
// Registered ALU select decoder with an iterative WIDTH-cycle multiply/divide
// sequencer, HI/LO registers and MFHI/MFLO readback.
module alu_control_md #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  alu_control_md_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [5:0] F_ADD  = 6'b100000, F_SUB  = 6'b100010, F_SLT   = 6'b101010;
  localparam logic [5:0] F_NOR  = 6'b100111, F_XOR  = 6'b100110, F_AND   = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101, F_MULT = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU = 6'b011011, F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mag_q, a_q, hi_q, lo_q, res_q;
  logic               div_q, sa_q, sb_q, bz_q;
  logic [2:0]         sel_q;
  logic               ill_q, done_q, rv_q;

  logic               rtype, md_arith, md_read, stall, start, signed_op;
  logic [2:0]         dec_sel;
  logic               dec_ill;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rem, fin_hi, fin_lo;
  logic [WIDTH:0]     mul_sum, div_rs, div_diff;
  logic [2*WIDTH-1:0] step, prod;

  always_comb begin
    dec_sel = 3'b000;
    dec_ill = 1'b0;
    if (rtype) begin
      case (bus.funct)
        F_ADD: dec_sel = 3'b000;
        F_SUB: dec_sel = 3'b001;
        F_SLT: dec_sel = 3'b010;
        F_NOR: dec_sel = 3'b011;
        F_XOR: dec_sel = 3'b100;
        F_AND: dec_sel = 3'b101;
        F_OR:  dec_sel = 3'b110;
        F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO: dec_sel = 3'b000;
        default: dec_ill = 1'b1;
      endcase
    end else begin
      case (bus.uc)
        3'b000:  dec_sel = 3'b000;
        3'b001:  dec_sel = 3'b001;
        3'b010:  dec_sel = 3'b010;
        3'b011:  dec_sel = 3'b100;
        3'b101:  dec_sel = 3'b101;
        3'b110:  dec_sel = 3'b110;
        default: dec_ill = 1'b1;
      endcase
    end
  end

  assign rtype     = bus.uc == 3'b111;
  assign md_arith  = rtype && (bus.funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
  assign md_read   = rtype && (bus.funct == F_MFHI || bus.funct == F_MFLO);
  assign stall     = bus.valid && (state_q == RUN) && (md_arith || md_read);
  assign start     = bus.valid && (state_q == IDLE) && md_arith;
  // funct[0] clear selects the signed flavour, funct[1] set selects divide
  assign signed_op = !bus.funct[0];
  assign mag_a     = (signed_op && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
  assign mag_b     = (signed_op && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;

  // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    div_rs   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_rs - {1'b0, mag_q};
    if (div_q)
      step = div_diff[WIDTH] ? {div_rs[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                             : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      step = {mul_sum, acc_q[WIDTH-1:1]};
    prod = (sa_q ^ sb_q) ? -step : step;
    quo  = step[WIDTH-1:0];
    rem  = step[2*WIDTH-1:WIDTH];
    if (!div_q) begin
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end else if (bz_q) begin
      fin_hi = a_q;
      fin_lo = '1;
    end else begin
      fin_hi = sa_q ? -rem : rem;
      fin_lo = (sa_q ^ sb_q) ? -quo : quo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mag_q   <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      sel_q   <= 3'b000;
      ill_q   <= 1'b0;
      done_q  <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rv_q   <= 1'b0;
      if (bus.valid && !stall) begin
        sel_q <= dec_sel;
        ill_q <= dec_ill;
      end
      if (bus.valid && state_q == IDLE && md_read) begin
        res_q <= (bus.funct == F_MFHI) ? hi_q : lo_q;
        rv_q  <= 1'b1;
      end
      case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          cnt_q   <= '0;
          div_q   <= bus.funct[1];
          sa_q    <= signed_op && bus.op_a[WIDTH-1];
          sb_q    <= signed_op && bus.op_b[WIDTH-1];
          bz_q    <= bus.op_b == '0;
          a_q     <= bus.op_a;
          mag_q   <= bus.funct[1] ? mag_b : mag_a;
          acc_q   <= bus.funct[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
        end
        RUN: begin
          acc_q <= step;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            hi_q    <= fin_hi;
            lo_q    <= fin_lo;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.alu_sel         = sel_q;
  assign bus.illegal         = ill_q;
  assign bus.busy            = state_q == RUN;
  assign bus.stall           = stall;
  assign bus.md_done         = done_q;
  assign bus.md_result       = res_q;
  assign bus.md_result_valid = rv_q;
endmodule

// File: tb/tb_alu_control_md.sv
// Randomized and directed bench for alu_control_md against an arithmetic
// reference model, plus an 8-bit instance for the narrow-width regression.
module tb_alu_control_md;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_control_md_if #(.WIDTH(32)) bus ();
  alu_control_md_if #(.WIDTH(8))  bus8 ();

  alu_control_md #(.WIDTH(32)) u_dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  alu_control_md #(.WIDTH(8))  u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_arith(input logic [2:0] uc, input logic [5:0] f);
    return uc == 3'b111 && (f == 6'b011000 || f == 6'b011001 || f == 6'b011010 || f == 6'b011011);
  endfunction

  function automatic bit is_read(input logic [2:0] uc, input logic [5:0] f);
    return uc == 3'b111 && (f == 6'b010000 || f == 6'b010010);
  endfunction

  function automatic void ref_decode(input logic [2:0] uc, input logic [5:0] f,
                                     output logic [2:0] sel, output logic ill);
    sel = 3'b000;
    ill = 1'b0;
    if (uc == 3'b111) begin
      case (f)
        6'b100000: sel = 3'd0;
        6'b100010: sel = 3'd1;
        6'b101010: sel = 3'd2;
        6'b100111: sel = 3'd3;
        6'b100110: sel = 3'd4;
        6'b100100: sel = 3'd5;
        6'b100101: sel = 3'd6;
        default:   ill = !(is_arith(uc, f) || is_read(uc, f));
      endcase
    end else if (uc == 3'b100) ill = 1'b1;
    else if (uc == 3'b011) sel = 3'b100;
    else sel = uc;
  endfunction

  function automatic void ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    hi = '0;
    lo = '0;
    case (f)
      6'b011000: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      6'b011001: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      6'b011010: begin
        if (b == 0) begin hi = a; lo = '1; end
        else begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
      end
      default: begin
        if (b == 0) begin hi = a; lo = '1; end
        else begin hi = a % b; lo = a / b; end
      end
    endcase
  endfunction

  // Reference state: what the block must present, derived from instruction semantics
  logic [2:0]  m_sel = 0;
  logic        m_ill = 0, m_busy = 0, m_done = 0, m_rv = 0;
  int          m_left = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0, m_res = 0;
  bit          m_arith, m_rd, m_stl;

  always @(posedge clk) begin
    if (rst) begin
      m_sel = 0; m_ill = 0; m_busy = 0; m_left = 0; m_hi = 0; m_lo = 0;
      m_done = 0; m_res = 0; m_rv = 0;
    end else begin
      m_arith = is_arith(bus.uc, bus.funct);
      m_rd    = is_read(bus.uc, bus.funct);
      m_stl   = bus.valid && m_busy && (m_arith || m_rd);
      m_done  = 0;
      m_rv    = 0;
      if (bus.valid && !m_stl) ref_decode(bus.uc, bus.funct, m_sel, m_ill);
      if (bus.valid && !m_busy && m_rd) begin
        m_res = (bus.funct == 6'b010000) ? m_hi : m_lo;
        m_rv  = 1;
      end
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; m_busy = 0; m_done = 1; end
      end else if (bus.valid && m_arith) begin
        ref_md(bus.funct, bus.op_a, bus.op_b, p_hi, p_lo);
        m_busy = 1;
        m_left = 32;
      end
    end
  end

  always @(negedge clk) begin
    chk("alu_sel", 64'(bus.alu_sel), 64'(m_sel));
    chk("illegal", 64'(bus.illegal), 64'(m_ill));
    chk("busy", 64'(bus.busy), 64'(m_busy));
    chk("stall", 64'(bus.stall),
        64'(bus.valid && m_busy && (is_arith(bus.uc, bus.funct) || is_read(bus.uc, bus.funct))));
    chk("md_done", 64'(bus.md_done), 64'(m_done));
    chk("md_result_valid", 64'(bus.md_result_valid), 64'(m_rv));
    chk("md_result", 64'(bus.md_result), 64'(m_res));
  end

  logic [5:0] flist [13] = '{6'b100000, 6'b100010, 6'b101010, 6'b100111, 6'b100110, 6'b100100,
                             6'b100101, 6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b010000,
                             6'b010010};
  logic        dn;
  int          wt, n;
  logic [2:0]  ru;
  logic [5:0]  rf;

  // Presents an instruction and holds it until a cycle with stall low consumes it
  task automatic issue(input logic [2:0] uc, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, output logic done_at_acc, output int waited);
    bit acc = 0;
    logic st;
    bus.valid = 1; bus.uc = uc; bus.funct = f; bus.op_a = a; bus.op_b = b;
    waited = 0;
    done_at_acc = 0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      st = bus.stall;
      done_at_acc = bus.md_done;
      @(posedge clk);
      #1;
      if (!st) acc = 1;
      else waited++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL issue_timeout: instruction uc=%0h funct=%0h never accepted", uc, f);
    end
    bus.valid = 0;
  endtask

  task automatic read_hl(input string name, input logic [31:0] ehi, input logic [31:0] elo);
    logic d; int w;
    issue(3'b111, 6'b010000, 0, 0, d, w);
    chk({name, "_hi"}, 64'(bus.md_result), 64'(ehi));
    chk({name, "_hi_vld"}, 64'(bus.md_result_valid), 64'd1);
    issue(3'b111, 6'b010010, 0, 0, d, w);
    chk({name, "_lo"}, 64'(bus.md_result), 64'(elo));
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (bus.md_done) break;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    bus.valid = 0; bus.uc = 0; bus.funct = 0; bus.op_a = 0; bus.op_b = 0;
    bus8.valid = 0; bus8.uc = 0; bus8.funct = 0; bus8.op_a = 0; bus8.op_b = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_alu_sel", 64'(bus.alu_sel), 64'd0);
    chk("rst_illegal", 64'(bus.illegal), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_md_done", 64'(bus.md_done), 64'd0);
    chk("rst_md_result", 64'(bus.md_result), 64'd0);
    chk("rst_md_result_valid", 64'(bus.md_result_valid), 64'd0);
    rst = 0;

    issue(3'b111, 6'b100111, 0, 0, dn, wt);
    chk("dec_nor", 64'({bus.illegal, bus.alu_sel}), 64'({1'b0, 3'b011}));
    issue(3'b111, 6'b000001, 0, 0, dn, wt);
    chk("dec_bad_funct", 64'({bus.illegal, bus.alu_sel}), 64'({1'b1, 3'b000}));
    issue(3'b011, 6'b000000, 0, 0, dn, wt);
    chk("dec_xori", 64'({bus.illegal, bus.alu_sel}), 64'({1'b0, 3'b100}));
    issue(3'b100, 6'b000000, 0, 0, dn, wt);
    chk("dec_uc100", 64'({bus.illegal, bus.alu_sel}), 64'({1'b1, 3'b000}));
    for (int u = 0; u < 8; u++)
      for (int k = 0; k < 13; k++)
        if (u == 7 || k == 0) begin
          issue(3'(u), flist[k], 0, 0, dn, wt);
          repeat (45) begin @(posedge clk); #1; end
        end

    issue(3'b111, 6'b011000, 32'hFFFFFFFD, 32'd7, dn, wt);
    wait_done(n);
    chk("mult_latency", 64'(n), 64'd32);
    read_hl("mult", 32'hFFFFFFFF, 32'hFFFFFFEB);
    issue(3'b111, 6'b011001, 32'hFFFFFFFD, 32'd7, dn, wt);
    wait_done(n);
    read_hl("multu", 32'h00000006, 32'hFFFFFFEB);
    issue(3'b111, 6'b011010, 32'hFFFFFFF9, 32'd2, dn, wt);
    wait_done(n);
    read_hl("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(3'b111, 6'b011011, 32'd7, 32'd0, dn, wt);
    wait_done(n);
    read_hl("divu_by0", 32'h00000007, 32'hFFFFFFFF);
    issue(3'b111, 6'b011010, 32'h80000000, 32'hFFFFFFFF, dn, wt);
    wait_done(n);
    read_hl("div_ovf", 32'h00000000, 32'h80000000);

    issue(3'b111, 6'b011000, 32'd5, 32'd6, dn, wt);
    issue(3'b111, 6'b100000, 0, 0, dn, wt);
    chk("add_midrun_wait", 64'(wt), 64'd0);
    chk("add_midrun_sel", 64'({bus.illegal, bus.alu_sel}), 64'd0);
    issue(3'b111, 6'b010010, 0, 0, dn, wt);
    chk("mflo_stall_cycles", 64'(wt), 64'd31);
    chk("mflo_after_done", 64'(bus.md_result), 64'h1E);
    chk("mflo_after_done_vld", 64'(bus.md_result_valid), 64'd1);

    issue(3'b111, 6'b011011, 32'd100, 32'd7, dn, wt);
    issue(3'b111, 6'b011011, 32'd50, 32'd3, dn, wt);
    chk("b2b_wait", 64'(wt), 64'd32);
    chk("b2b_accept_in_done", 64'(dn), 64'd1);
    chk("b2b_busy_again", 64'(bus.busy), 64'd1);
    issue(3'b111, 6'b010000, 0, 0, dn, wt);
    chk("b2b_hi", 64'(bus.md_result), 64'd2);

    for (int i = 0; i < 200; i++) begin
      ru = ($urandom_range(0, 3) != 0) ? 3'd7 : 3'($urandom_range(0, 6));
      rf = ($urandom_range(0, 4) != 0) ? flist[$urandom_range(0, 12)] : 6'($urandom);
      issue(ru, rf, pick(), pick(), dn, wt);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 5)) begin @(posedge clk); #1; end
    end
    repeat (40) begin @(posedge clk); #1; end

    issue(3'b111, 6'b011011, 32'd9, 32'd4, dn, wt);
    wait_done(n);
    issue(3'b111, 6'b011010, 32'd1000, 32'd3, dn, wt);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_midrun_busy", 64'(bus.busy), 64'd0);
    chk("rst_midrun_done", 64'(bus.md_done), 64'd0);
    read_hl("rst_midrun", 32'd0, 32'd0);

    bus8.valid = 1; bus8.uc = 3'b111; bus8.funct = 6'b011000; bus8.op_a = 8'h80; bus8.op_b = 8'h80;
    @(posedge clk); #1;
    bus8.valid = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus8.md_done) break;
    end
    chk("w8_latency", 64'(n), 64'd8);
    bus8.valid = 1; bus8.funct = 6'b010000;
    @(posedge clk); #1;
    chk("w8_mult_hi", 64'(bus8.md_result), 64'h40);
    bus8.funct = 6'b010010;
    @(posedge clk); #1;
    chk("w8_mult_lo", 64'(bus8.md_result), 64'h00);
    bus8.valid = 0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_control_md.md
# alu_control_md

Parametrised, registered successor to the datapath ALU control decoder. Decodes the control-unit ALU class (`uc`) and R-type `funct` into the 3-bit ALU select with a defined default and an illegal flag. Adds an iterative multiply/divide sequencer with HI/LO registers, a busy/stall handshake and MFHI/MFLO readback. Sits between the control unit/register-file read stage and the ALU in the datapath.

## Interface
- `WIDTH`, 32, operand, HI and LO width (≥ 4)
- `clk`  in  1  clock, all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `valid`  in  1  instruction presented this cycle
- `uc`  in  3  ALU class from control unit
- `funct`  in  6  instruction[5:0]
- `op_a`  in  WIDTH  rs operand (multiplicand / dividend)
- `op_b`  in  WIDTH  rt operand (multiplier / divisor)
- `alu_sel`  out  3  registered ALU operation select
- `illegal`  out  1  registered: last decoded uc/funct unsupported
- `busy`  out  1  multiply/divide in progress
- `stall`  out  1  combinational: `valid & busy & funct ∈ {MD, MFHI, MFLO}` while `uc==3'b111`
- `md_done`  out  1  one-cycle pulse, HI/LO just updated
- `md_result`  out  WIDTH  registered HI or LO readback
- `md_result_valid`  out  1  one-cycle pulse qualifying `md_result`

## Operation
- Decode, registered when `valid & !stall`; otherwise `alu_sel`/`illegal` hold.
- `uc=111`: funct 100000→000 add, 100010→001 sub, 101010→010 slt, 100111→011 nor, 100110→100 xor, 100100→101 and, 100101→110 or. MD functs 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010010 mflo → `alu_sel`=000, `illegal`=0. Any other funct → 000, `illegal`=1.
- `uc` 000→000 addi, 001→001 sub, 010→010 slti, 011→100 xori, 101→101 andi, 110→110 ori; 100→000 with `illegal`=1.
- Never latches a stale value: every accepted decode writes both outputs.
- MD start: `valid & !busy & uc==111` with MD funct captures `op_a`/`op_b`, op kind and signedness.
- Sequencer states IDLE→RUN→IDLE. RUN counter 0..WIDTH-1, one shift-add (mult) or restoring-subtract (div) step per cycle on magnitudes; sign fix-up applied on the final step.
- mult/multu: {HI,LO} = full 2·WIDTH product.
- div/divu: LO = quotient (truncated toward zero), HI = remainder (sign of dividend).
- Divide by zero: HI = op_a, LO = all ones; no trap. Signed −2^(WIDTH−1) / −1: LO = −2^(WIDTH−1), HI = 0.
- MFHI/MFLO when not busy: `md_result` ← HI/LO, `md_result_valid` pulses.
- While busy: non-MD instructions still decode normally; MD/MFHI/MFLO raise `stall` and are not consumed (upstream must hold them).

## Timing
- Reset values: `alu_sel`=000, `illegal`=0, `busy`=0, `md_done`=0, `md_result`=0, `md_result_valid`=0, HI=LO=0, state IDLE.
- Decode latency: 1 cycle (inputs at edge E → outputs valid after E).
- MD: accepted at edge E0; `busy`=1 after E0 through edge E_WIDTH; at E_WIDTH HI/LO written, `busy`→0, `md_done`=1 for exactly the following cycle. Latency WIDTH cycles; no early termination.
- New MD op may be accepted in the cycle `md_done` is high (back-to-back, zero bubble).
- MFHI in the `md_done` cycle returns the new HI, visible one edge later.
- Reset mid-RUN: aborts, HI/LO cleared, `md_done` not pulsed.
- `stall` depends only on current inputs and `busy`; no registered delay.

## Test plan
- Reset then sweep all decode encodings: uc=111/funct=100111 → `alu_sel`=011, `illegal`=0; uc=111/funct=000001 → 000, `illegal`=1; uc=011 → 100; uc=100 → 000, `illegal`=1.
- WIDTH=32, mult op_a=−3 (0xFFFFFFFD), op_b=7 → `md_done` exactly 32 cycles after accept, HI=0xFFFFFFFF, LO=0xFFFFFFEB; multu same operands → HI=0x00000006, LO=0xFFFFFFEB.
- div −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 → HI=7, LO=0xFFFFFFFF; div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Issue mult, then mflo while busy → `stall`=1 every busy cycle, mflo serviced the cycle after `md_done`, `md_result_valid` pulses with LO; an `add` issued mid-run decodes to 000 with no stall.
- Back-to-back: second divu held at `valid` until `md_done` cycle → accepted that cycle, `busy` never drops low between ops.
- Assert `rst` at cycle 10 of a divide → next cycle `busy`=0, HI=LO=0, no `md_done`; WIDTH=8 regression of mult 0x80×0x80 signed → HI=0x40, LO=0x00.
